// File: rtl/mux_gate_sched_pkg.sv
// rtl/mux_gate_sched_pkg.sv - shared op and FSM state types for mux_gate_sched
//
// Purpose: op-code and scheduler state enums used by mux_gate_sched and
//          mux_gate_unit.
// Ports:   none (package).
package mux_gate_sched_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NAND = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/mux_gate_unit.sv
// rtl/mux_gate_unit.sv - combinational bitwise logic unit built from 2:1 muxes on A
//
// Purpose: computes AND/OR/NAND/XOR of a and b. Every result bit is a 2:1 mux
//          selected by the matching bit of a; op picks the two data inputs,
//          which are constants or b.
// Ports:
//   op  in  2  operation (OP_AND, OP_OR, OP_NAND, OP_XOR)
//   a   in  W  operand A, drives the mux selects
//   b   in  W  operand B
//   y   out W  result
module mux_gate_unit
  import mux_gate_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // d1 is selected where a=1, d0 where a=0
  logic [W-1:0] d1;
  logic [W-1:0] d0;

  always_comb begin
    d1 = '0;
    d0 = '0;
    case (op_e'(op))
      OP_AND:  begin d1 = b;  d0 = '0; end
      OP_OR:   begin d1 = '1; d0 = b;  end
      OP_NAND: begin d1 = ~b; d0 = '1; end
      OP_XOR:  begin d1 = ~b; d0 = b;  end
      default: begin d1 = '0; d0 = '0; end
    endcase
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) begin
      y[i] = a[i] ? d1[i] : d0[i];
    end
  end

endmodule

// File: rtl/mux_gate_sched.sv
// rtl/mux_gate_sched.sv - round-robin scheduler sharing one mux_gate_unit among N_REQ requesters
//
// Purpose: grants one requester per transaction (round-robin from rr_ptr),
//          runs its op through mux_gate_unit and registers the result with the
//          requester index. Optional completion counter under
//          MUX_GATE_SCHED_STATS_EN.
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            asynchronous active-low reset
//   req_valid  in  N_REQ        per-requester request valid
//   req_ready  out N_REQ        one-hot (or zero) accept, combinational
//   req_op     in  2*N_REQ      op per requester, slice i = [2i+1:2i]
//   req_a      in  W*N_REQ      operand A per requester
//   req_b      in  W*N_REQ      operand B per requester
//   rsp_valid  out 1            registered result valid
//   rsp_ready  in  1            consumer accepts result
//   rsp_id     out clog2(N_REQ) requester index of the result
//   rsp_y      out W            registered result
//   op_cnt     out 16           completed responses, saturating (MUX_GATE_SCHED_STATS_EN only)
module mux_gate_sched
  import mux_gate_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [W*N_REQ-1:0]       req_a,
  input  logic [W*N_REQ-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_y
`ifdef MUX_GATE_SCHED_STATS_EN
  ,
  output logic [15:0]              op_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  state_e          state_q;
  state_e          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            found;
  logic [1:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [W-1:0]    unit_y;
  logic            accept;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Walk the ring from the farthest offset back to rr_ptr so the last hit,
  // i.e. the first valid at or after rr_ptr, wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) begin
        grant = wrap_idx(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held even with valids up
  assign accept = rst_n && (state_q == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign sel_op = req_op[2*int'(grant) +: 2];
  assign sel_a  = req_a[W*int'(grant) +: W];
  assign sel_b  = req_b[W*int'(grant) +: W];

  mux_gate_unit #(.W(W)) u_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)     state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      rsp_y     <= unit_y;
      rr_ptr    <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MUX_GATE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (rsp_valid && rsp_ready && op_cnt != 16'hFFFF) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_gate_sched.sv
// tb/tb_mux_gate_sched.sv - self-checking bench for mux_gate_sched
module tb_mux_gate_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_y;
`ifdef MUX_GATE_SCHED_STATS_EN
  logic [15:0]    op_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  mux_gate_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
`ifdef MUX_GATE_SCHED_STATS_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_ptr = 0;
  bit        m_busy = 0;
  bit        m_valid = 0;
  int        m_id = 0;
  int        m_y = 0;

  function automatic int op_result(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return (~(a & b)) & 8'hFF;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int first_valid(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_busy = 0; m_valid = 0; m_id = 0; m_y = 0;
    end else if (!m_busy) begin
      int g;
      g = first_valid(req_valid, m_ptr);
      if (g >= 0) begin
        m_y     = op_result(int'(req_op[2*g +: 2]), int'(req_a[W*g +: W]), int'(req_b[W*g +: W]));
        m_id    = g;
        m_valid = 1;
        m_busy  = 1;
        m_ptr   = (g + 1) % N;
      end
    end else if (rsp_ready) begin
      m_valid = 0;
      m_busy  = 0;
    end
  end

  // single compare process, sampling away from the active edge
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      int g;
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      g = first_valid(req_valid, m_ptr);
      if (!m_busy && g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", int'(req_ready), int'(exp_rdy));
      check("rsp_valid", int'(rsp_valid), int'(m_valid));
      if (m_valid) begin
        check("rsp_id", int'(rsp_id), m_id);
        check("rsp_y", int'(rsp_y), m_y);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int op, input int a, input int b);
    req_op[2*r +: 2] = 2'(op);
    req_a[W*r +: W]  = W'(a);
    req_b[W*r +: W]  = W'(b);
  endtask

  // raise req r and hold until accepted; returns just after the accepting edge
  task automatic send(input int r, input int op, input int a, input int b);
    bit done;
    done = 0;
    set_req(r, op, a, b);
    req_valid[r] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (req_ready[r]) done = 1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: requester %0d never granted", r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[$];
    logic [W-1:0] held;
    int exp_ops[4];
    exp_ops = '{8'hC0, 8'hFC, 8'h3F, 8'h3C};

    // reset state
    #2;
    check("reset_req_ready", int'(req_ready), 0);
    req_valid = 4'b1111;
    #1;
    check("reset_req_ready_held", int'(req_ready), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_y", int'(rsp_y), 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // single request
    rsp_ready = 1'b1;
    send(0, 0, 8'hF0, 8'hCC);
    @(negedge clk);
    check("single_valid", int'(rsp_valid), 1);
    check("single_y", int'(rsp_y), 8'hC0);
    check("single_id", int'(rsp_id), 0);
    tick();

    // all four ops from requester 2
    for (int op = 0; op < 4; op++) begin
      send(2, op, 8'hF0, 8'hCC);
      @(negedge clk);
      check("ops_y", int'(rsp_y), exp_ops[op]);
      check("ops_id", int'(rsp_id), 2);
      tick();
    end

    // round-robin fairness from rr_ptr=0
    pulse_reset();
    req_valid = 4'b1111;
    for (int n = 0; n < 40 && ids.size() < 5; n++) begin
      @(negedge clk);
      if (rsp_valid) ids.push_back(int'(rsp_id));
    end
    req_valid = '0;
    check("rr_count", ids.size(), 5);
    for (int i = 0; i < ids.size() && i < 5; i++)
      check("rr_order", ids[i], i % 4);
    tick();
    tick();

    // backpressure
    rsp_ready = 1'b0;
    send(1, 3, 8'h5A, 8'h0F);
    req_valid[3] = 1'b1;
    set_req(3, 1, 8'h11, 8'h22);
    held = 8'h55;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_id", int'(rsp_id), 1);
      check("bp_y", int'(rsp_y), int'(held));
      check("bp_ready", int'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_last", int'(req_ready), 0);
    @(negedge clk);
    check("bp_next_grant", int'(req_ready), 4'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();

    // reset mid-operation
    rsp_ready = 1'b0;
    send(2, 1, 8'h0F, 8'hA0);
    @(negedge clk);
    check("rst_pre_valid", int'(rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(rsp_valid), 0);
    check("rst_async_ready", int'(req_ready), 0);
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", int'(req_ready), 4'b0010);
    tick();
    req_valid = '0;
    tick();

`ifdef MUX_GATE_SCHED_STATS_EN
    pulse_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      send(t, t, 8'h3C, 8'hA5);
      tick();
    end
    @(negedge clk);
    check("stats_cnt3", int'(op_cnt), 3);
    #2;
    force dut.op_cnt = 16'hFFFF;
    #1;
    release dut.op_cnt;
    tick();
    send(1, 0, 8'h01, 8'h01);
    tick();
    @(negedge clk);
    check("stats_sat", int'(op_cnt), 16'hFFFF);
    tick();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_op    = (2*N)'($urandom);
      req_a     = (W*N)'($urandom);
      req_b     = (W*N)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_gate_sched.md
# mux_gate_sched

Round-robin scheduler that shares a single mux-built bitwise logic unit (AND/OR/NAND/XOR, each realised as a 2:1 mux selecting on operand A) among N requesters. Each requester presents an op code and two W-bit operands over a valid/ready handshake. The block grants one requester and registers the result with the requester's ID on a single response port. It sits between the requester front-ends and the mux gate datapath, and is the only path into that datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand/result width (bitwise ops)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_op  in  2*N_REQ  op per requester, slice i = [2i+1:2i]: 00 AND, 01 OR, 10 NAND, 11 XOR
- req_a  in  W*N_REQ  operand A per requester, slice i = [W*i+W-1:W*i]
- req_b  in  W*N_REQ  operand B per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(N_REQ)  index of the requester that produced the result
- rsp_y  out  W  result

## Operation
- FSM states: IDLE, RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the first asserted req_valid at or after index rr_ptr, wrapping modulo N_REQ.
  - req_ready[grant] = 1 combinationally; all other bits are 0. If no req_valid is asserted, req_ready = 0.
  - On the clock edge: op, a and b of the granted requester are routed through the logic unit. rsp_y, rsp_id, rsp_valid=1 are registered. rr_ptr becomes (grant+1) mod N_REQ. State moves to RESP.
- RESP:
  - req_ready = 0. rsp_valid, rsp_id and rsp_y are held stable until rsp_ready=1.
  - On rsp_ready=1: rsp_valid is cleared on the edge and state returns to IDLE.
- Logic unit results:
  - AND = A&B
  - OR = A|B
  - NAND = ~A|~B
  - XOR = A^B
- A requester may drop req_valid before it is granted. Arbitration is re-evaluated every IDLE cycle.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_y=0, rr_ptr=0.
  - req_ready=0 for the whole time rst_n=0.
- Reset asserted mid-operation discards any pending response immediately (asynchronous). Nothing is replayed.

## Timing
- Accept-to-response latency: 1 cycle. A handshake at edge t gives rsp_valid=1 in the cycle after t.
- Maximum throughput is one transaction per 2 cycles: the IDLE accept cycle, then at least one RESP cycle.
- If rsp_ready is already 1 when RESP is entered, RESP lasts exactly 1 cycle.
- A requester that stays asserted waits at most N_REQ−1 other grants before it is served.
- When requests arrive simultaneously, only rr_ptr decides the winner. There is no fixed priority.
- rsp_* outputs are fully registered. req_ready is combinational from the state and req_valid.

## Configuration
- MUX_GATE_SCHED_STATS_EN defined:
  - Adds an output port op_cnt (16 bits). It counts completed responses, i.e. rsp_valid&rsp_ready edges.
  - op_cnt saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package mux_gate_sched_pkg holds:
  - the op enum: OP_AND=2'b00, OP_OR=2'b01, OP_NAND=2'b10, OP_XOR=2'b11
  - the FSM state enum: IDLE, RESP
- Sub-module mux_gate_unit:
  - purely combinational, W-wide
  - inputs op, a, b; output y
  - each function is built as a 2:1 mux on A, with constants and B as the data inputs
- The arbiter (rr_ptr plus grant logic) is inline in mux_gate_sched.

## Test plan
- **Single request.** Requester 0 sends op=AND, a=8'hF0, b=8'hCC; rsp_ready held 1.
  - Required: rsp_y=8'hC0 and rsp_id=0, one cycle after the handshake.
- **All four ops.** Requester 2 sends each op in turn with a=8'hF0, b=8'hCC.
  - Required: results C0, FC, 3F, 3C in order, rsp_id=2 each time.
- **Round-robin fairness.** All 4 requesters hold req_valid continuously.
  - Required: grant order 0,1,2,3,0; req_ready one-hot and only in IDLE.
- **Backpressure.** rsp_ready=0 for 5 cycles after a response.
  - Required: rsp_valid, rsp_id and rsp_y stable; req_ready=0 throughout; the next grant comes only in the IDLE cycle after rsp_ready=1.
- **Reset mid-operation.** Drop rst_n while in RESP.
  - Required: rsp_valid goes to 0 immediately. After release, the first grant goes to the lowest asserted index (rr_ptr=0).
- **Stats (with MUX_GATE_SCHED_STATS_EN).** Run 3 transactions.
  - Required: op_cnt=3. After the counter is forced to 16'hFFFF, one more completion leaves it at 16'hFFFF.
